mem_stage_lsu: RTL and testbench



---
 rtl/mem_pkg.sv | 26 ++
 rtl/load_extend.sv | 21 ++
 rtl/mem_stage_lsu.sv | 154 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: funct3 codes, FSM state encoding, byte-enable constants and size decode shared by the MEM stage.
package mem_pkg;
    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [3:0] BE_B   = 4'b0001;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, WB} state_t;

    // Any funct3 that is neither byte nor halfword is handled as a word access.
    function automatic logic is_byte(input logic [2:0] f3);
        return f3 == F3_B || f3 == F3_BU;
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return f3 == F3_H || f3 == F3_HU;
    endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a load word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        sgn;

    always_comb begin
        b    = rdata[{addr_lo, 3'b000} +: 8];
        h    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        sgn  = ~funct3[2];
        data = is_byte(funct3) ? {{24{sgn & b[7]}}, b} :
               is_half(funct3) ? {{16{sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I MEM stage - BEQ/BNE resolution, single-outstanding dmem port, load extension, registered WB handoff.
// Optional MISALIGN_TRAP_EN adds misalign_trap and bypasses the memory port for misaligned halfword/word accesses.
module mem_stage_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
`ifdef MISALIGN_TRAP_EN
    output logic              misalign_trap,
`endif
    output logic              pc_src,
    output logic [DATA_W-1:0] pc_target
);
    state_t      state;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lo;
    logic        lat_reg_write;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        taken;
    logic        is_mem;
    logic        misaligned;

    always_comb begin
        st_be    = is_byte(ex_funct3) ? BE_B << ex_alu_result[1:0] :
                   is_half(ex_funct3) ? (ex_alu_result[1] ? BE_HHI : BE_HLO) : BE_W;
        st_wdata = is_byte(ex_funct3) ? {4{ex_store_data[7:0]}} :
                   is_half(ex_funct3) ? {2{ex_store_data[15:0]}} : ex_store_data;
        taken    = ex_branch && ((ex_funct3 == F3_BEQ && ex_zero) || (ex_funct3 == F3_BNE && !ex_zero));
        is_mem   = ex_mem_read || ex_mem_write;
`ifdef MISALIGN_TRAP_EN
        misaligned = is_mem && (is_half(ex_funct3) ? ex_alu_result[0] :
                     !is_byte(ex_funct3) && ex_alu_result[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
    end

    load_extend u_load_extend (
        .rdata   (dmem_rdata),
        .addr_lo (lat_lo),
        .funct3  (lat_f3),
        .data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ex_ready      <= 1'b1;
            lat_f3        <= '0;
            lat_lo        <= '0;
            lat_reg_write <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_be       <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            pc_src        <= 1'b0;
            pc_target     <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            pc_src   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalign_trap <= 1'b0;
`endif
            case (state)
                IDLE: if (ex_valid) begin
                    ex_ready      <= 1'b0;
                    lat_f3        <= ex_funct3;
                    lat_lo        <= ex_alu_result[1:0];
                    lat_reg_write <= ex_reg_write;
                    wb_rd         <= ex_rd;
                    wb_data       <= ex_alu_result;
                    pc_target     <= ex_branch_target;
                    pc_src        <= taken;
                    if (misaligned) begin
                        state        <= WB;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                        misalign_trap <= 1'b1;
`endif
                    end else if (is_mem) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_write;
                        dmem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                        dmem_be    <= st_be;
                        dmem_wdata <= st_wdata;
                    end else begin
                        state        <= WB;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= ex_reg_write;
                    end
                end
                REQ: if (dmem_gnt) begin
                    dmem_req <= 1'b0;
                    if (dmem_we) begin
                        state        <= WB;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= 1'b0;
                    end else begin
                        state <= WAIT_RSP;
                    end
                end
                WAIT_RSP: if (dmem_rvalid) begin
                    state        <= WB;
                    wb_valid     <= 1'b1;
                    wb_data      <= ld_data;
                    wb_reg_write <= lat_reg_write;
                end
                default: begin
                    state    <= IDLE;
                    ex_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu (covers MISALIGN_TRAP_EN when defined).
module tb_mem_stage_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_alu_result, ex_store_data, ex_branch_target;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read, ex_mem_write, ex_branch, ex_zero, ex_reg_write;
    logic [4:0]  ex_rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_reg_write, pc_src;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, pc_target;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
`ifdef MISALIGN_TRAP_EN
        .misalign_trap(misalign_trap),
`endif
        .pc_src(pc_src), .pc_target(pc_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] tgt,
                         input logic [2:0] f3, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw, input logic br, input logic z);
        chk("ready_before_issue", ex_ready, 1);
        ex_alu_result = alu; ex_store_data = sd; ex_branch_target = tgt; ex_funct3 = f3;
        ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
        ex_branch = br; ex_zero = z; ex_valid = 1'b1;
        step;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_branch = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] exp);
        logic [31:0] al;
        al = {addr[31:2], 2'b00};
        issue(addr, 32'h0, 32'h0, f3, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, 0);
        chk({tag, "_addr"}, dmem_addr, al);
        dmem_gnt = 1'b1;
        step;
        dmem_gnt = 1'b0;
        chk({tag, "_wait_req_low"}, dmem_req, 0);
        chk({tag, "_wait_no_wb"}, wb_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        step;
        dmem_rvalid = 1'b0;
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_rd"}, wb_rd, 9);
        chk({tag, "_rw"}, wb_reg_write, 1);
        step;
        chk({tag, "_wb_pulse"}, wb_valid, 0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data, input logic [31:0] exp_wd, input logic [3:0] exp_be);
        logic [31:0] al;
        al = {addr[31:2], 2'b00};
        issue(addr, data, 32'h0, f3, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_we"}, dmem_we, 1);
        chk({tag, "_addr"}, dmem_addr, al);
        chk({tag, "_be"}, {28'h0, dmem_be}, {28'h0, exp_be});
        chk({tag, "_wdata"}, dmem_wdata, exp_wd);
        dmem_gnt = 1'b1;
        step;
        dmem_gnt = 1'b0;
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_wb_rw"}, wb_reg_write, 0);
        chk({tag, "_req_low"}, dmem_req, 0);
        step;
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_branch_target = '0; ex_funct3 = '0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_branch = 1'b0; ex_zero = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ex_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_pc_target", pc_target, 0);
        rst_n = 1'b1;
        step;

        // ALU op
        issue(32'h0000_1234, 32'h0, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_rw", wb_reg_write, 1);
        chk("alu_no_req", dmem_req, 0);
        chk("alu_not_ready", ex_ready, 0);
        step;
        chk("alu_pulse", wb_valid, 0);
        chk("alu_ready_again", ex_ready, 1);

        // rvalid while idle must be ignored
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step;
        step;
        dmem_rvalid = 1'b0;
        chk("idle_rvalid_no_wb", wb_valid, 0);
        chk("idle_rvalid_ready", ex_ready, 1);

        // SB with grant delayed three cycles
        issue(32'h0000_0103, 32'hAABB_CCDD, 32'h0, F3_B, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("sb_req_held", dmem_req, 1);
            chk("sb_addr", dmem_addr, 32'h100);
            chk("sb_be", {28'h0, dmem_be}, 32'h8);
            chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
            chk("sb_not_ready", ex_ready, 0);
            chk("sb_no_wb", wb_valid, 0);
            if (i == 3) dmem_gnt = 1'b1;
            step;
        end
        dmem_gnt = 1'b0;
        chk("sb_wb_valid", wb_valid, 1);
        chk("sb_wb_rw", wb_reg_write, 0);
        chk("sb_req_low", dmem_req, 0);
        step;

        do_store("sh_hi", 32'h0000_0102, F3_H, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b1100);
        do_store("sh_lo", 32'h0000_0100, F3_H, 32'h1234_ABCD, 32'hABCD_ABCD, 4'b0011);
        do_store("sw", 32'h0000_0200, F3_W, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111);
        do_store("sb0", 32'h0000_0300, F3_B, 32'h0000_005A, 32'h5A5A_5A5A, 4'b0001);

        // Both read and write set: store wins
        issue(32'h0000_0010, 32'h0000_0077, 32'h0, F3_W, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rw_both_we", dmem_we, 1);
        dmem_gnt = 1'b1;
        step;
        dmem_gnt = 1'b0;
        chk("rw_both_wb_rw", wb_reg_write, 0);
        step;

        // LB with rvalid high before grant (ignored) and a one-cycle grant delay
        issue(32'h0000_0101, 32'h0, 32'h0, F3_B, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
        step;
        dmem_rvalid = 1'b0;
        chk("lb_req_held", dmem_req, 1);
        chk("lb_early_rvalid_no_wb", wb_valid, 0);
        dmem_gnt = 1'b1;
        step;
        dmem_gnt = 1'b0;
        chk("lb_wait_no_wb", wb_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8000;
        step;
        dmem_rvalid = 1'b0;
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_data", wb_data, 32'hFFFF_FF80);
        chk("lb_rd", wb_rd, 7);
        step;

        do_load("lbu", 32'h0000_0101, F3_BU, 32'h0000_8000, 32'h0000_0080);
        do_load("lh", 32'h0000_0102, F3_H, 32'h8001_0000, 32'hFFFF_8001);
        do_load("lhu", 32'h0000_0102, F3_HU, 32'h8001_0000, 32'h0000_8001);
        do_load("lb3", 32'h0000_0103, F3_B, 32'h7F00_0000, 32'h0000_007F);
        do_load("lh0", 32'h0000_0100, F3_H, 32'h0000_F00F, 32'hFFFF_F00F);
        do_load("lw", 32'h0000_0104, F3_W, 32'h1234_5678, 32'h1234_5678);
        do_load("lundef", 32'h0000_0108, 3'b111, 32'h8765_4321, 32'h8765_4321);

        // Branches
        issue(32'h0, 32'h0, 32'h0000_0040, F3_BEQ, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("beq_taken", pc_src, 1);
        chk("beq_target", pc_target, 32'h40);
        step;
        chk("beq_pulse", pc_src, 0);
        chk("beq_target_held", pc_target, 32'h40);
        issue(32'h0, 32'h0, 32'h0000_0080, F3_BNE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bne_z1_not_taken", pc_src, 0);
        chk("bne_target", pc_target, 32'h80);
        step;
        issue(32'h0, 32'h0, 32'h0000_00C0, F3_BNE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bne_z0_taken", pc_src, 1);
        step;
        issue(32'h0, 32'h0, 32'h0000_0100, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("blt_not_taken", pc_src, 0);
        step;

`ifdef MISALIGN_TRAP_EN
        issue(32'h0000_0102, 32'h0, 32'h0, F3_W, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mis_no_req", dmem_req, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_trap", misalign_trap, 1);
        chk("mis_wb_rw", wb_reg_write, 0);
        step;
        chk("mis_trap_pulse", misalign_trap, 0);
        issue(32'h0000_0103, 32'h0, 32'h0, F3_H, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("mis_sh_trap", misalign_trap, 1);
        chk("mis_sh_no_req", dmem_req, 0);
        step;
        do_load("al_lh", 32'h0000_0102, F3_H, 32'h8001_0000, 32'hFFFF_8001);
`else
        do_load("mis_lw", 32'h0000_0102, F3_W, 32'h1122_3344, 32'h1122_3344);
        do_load("mis_lh", 32'h0000_0103, F3_H, 32'h8001_0000, 32'hFFFF_8001);
`endif

        // Reset while waiting for load data
        issue(32'h0000_0204, 32'h0, 32'h0, F3_W, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        dmem_gnt = 1'b1;
        step;
        dmem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_ready", ex_ready, 1);
        chk("rst_wait_no_wb", wb_valid, 0);
        chk("rst_wait_req", dmem_req, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_5555;
        step;
        rst_n = 1'b1;
        step;
        dmem_rvalid = 1'b0;
        chk("post_rst_no_wb", wb_valid, 0);
        chk("post_rst_ready", ex_ready, 1);
        issue(32'h0000_00AB, 32'h0, 32'h0, 3'b000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_alu", wb_data, 32'hAB);
        chk("post_rst_alu_valid", wb_valid, 1);
        step;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
